// File: rtl/shift_seq8_pkg.sv
// rtl/shift_seq8_pkg.sv - opcodes, FSM states and command record for the shifter sequencer
package shift_seq8_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  // Largest distance the shifter can move in a single cycle.
  localparam logic [3:0] MAX_STEP = 4'd3;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] data;
  } cmd_t;

  function automatic logic is_shift(input logic [2:0] o);
    return (o == OP_LSL) || (o == OP_LSR) || (o == OP_ASR);
  endfunction

  // Per-cycle distance: whatever is left, capped at the shifter's step size.
  function automatic logic [1:0] step_amt(input logic [3:0] r);
    return (r > MAX_STEP) ? 2'd3 : r[1:0];
  endfunction

endpackage

// File: rtl/shift_seq8_if.sv
// rtl/shift_seq8_if.sv - command handshake bundle into the sequencer
interface shift_seq8_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amt;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_amt,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_amt,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/shift_seq8_cmd_fifo.sv
// rtl/shift_seq8_cmd_fifo.sv - circular command buffer with registered fill count
module cmd_fifo
  import shift_seq8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Full and empty come straight from the registered count so ready has no input path.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - expands buffered commands into per-cycle shifter operations
module shift_seq8
  import shift_seq8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  shift_seq8_if.slave  cmd,
  output logic [2:0]   op,
  output logic [1:0]   shamt,
  output logic [7:0]   d_in,
  output logic         done,
  output logic         busy
);

  cmd_t       push_data;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  state_t     state;
  state_t     state_n;
  logic [2:0] cur_op;
  logic [2:0] cur_op_n;
  logic [3:0] remain;
  logic [3:0] remain_n;
  logic [2:0] op_n;
  logic [1:0] shamt_n;
  logic [7:0] d_in_n;
  logic       done_n;

  assign push_data     = {cmd.cmd_op, cmd.cmd_amt, cmd.cmd_data};
  assign cmd.cmd_ready = !fifo_full;
  assign push          = cmd.cmd_valid && !fifo_full;

  // done is the registered "final step on the outputs now" flag, so the next
  // command can be popped on the same edge the last step is consumed.
  assign pop  = !fifo_empty && ((state == S_IDLE) || done);
  assign busy = !fifo_empty || (state == S_ISSUE);

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next step: first step of a popped command, a continuation step, or the idle word.
  always_comb begin
    state_n  = state;
    cur_op_n = cur_op;
    remain_n = remain;
    op_n     = OP_NOP;
    shamt_n  = 2'd0;
    d_in_n   = 8'd0;
    done_n   = 1'b0;

    if (pop) begin
      state_n  = S_ISSUE;
      cur_op_n = head.op;
      remain_n = 4'd0;
      if (is_shift(head.op) && (head.amt != 4'd0)) begin
        op_n     = head.op;
        shamt_n  = step_amt(head.amt);
        remain_n = head.amt - {2'b00, step_amt(head.amt)};
        done_n   = (head.amt <= MAX_STEP);
      end else if (head.op == OP_LOAD) begin
        op_n   = OP_LOAD;
        d_in_n = head.data;
        done_n = 1'b1;
      end else begin
        // NOP, illegal opcodes and zero-distance shifts all collapse to one NOP step.
        done_n = 1'b1;
      end
    end else if ((state == S_ISSUE) && !done) begin
      op_n     = cur_op;
      shamt_n  = step_amt(remain);
      remain_n = remain - {2'b00, step_amt(remain)};
      done_n   = (remain <= MAX_STEP);
    end else begin
      state_n  = S_IDLE;
      remain_n = 4'd0;
    end
  end

  // State, step counter and the output word all advance together on the clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cur_op <= OP_NOP;
      remain <= 4'd0;
      op     <= OP_NOP;
      shamt  <= 2'd0;
      d_in   <= 8'd0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cur_op <= cur_op_n;
      remain <= remain_n;
      op     <= op_n;
      shamt  <= shamt_n;
      d_in   <= d_in_n;
      done   <= done_n;
    end
  end

endmodule

// File: doc/shift_seq8.md
# shift_seq8

Command sequencer that sits directly upstream of the 8-bit loadable shifter and drives its `op`, `shamt` and `d_in` inputs. Commands arrive over a valid/ready handshake and are buffered in a 4-entry FIFO. Each command is expanded into one or more per-cycle shifter operations, so a shift of up to 15 positions is split into steps of at most 3. The result register stays inside the shifter; this block only issues operations and flags command completion.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high. Sampled on `clk`.
- `cmd_valid`  in  1  a command is offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_op`  in  3  shifter opcode: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR; 101–111 are treated as NOP.
- `cmd_amt`  in  4  total shift distance 0–15; ignored for NOP and LOAD.
- `cmd_data`  in  8  load value; ignored unless LOAD.
- `op`  out  3  registered opcode to the shifter.
- `shamt`  out  2  registered per-step shift amount.
- `d_in`  out  8  registered load data.
- `done`  out  1  registered; high in the issue cycle of each command's final step.
- `busy`  out  1  high when the FIFO is non-empty or a command is in progress.

## Operation
- **Handshake.** A command is accepted when `cmd_valid && cmd_ready` at an edge. Inputs need not be held after acceptance. With `cmd_valid` high and `cmd_ready` low, the command stays pending and nothing is dropped.
- **FSM states.**
  - IDLE: outputs hold the idle word.
  - ISSUE: a command is being expanded; holds `cur_op` and `remain` (4 bits).
- **Pop and first step.** A command is popped when the FSM is in IDLE with the FIFO non-empty, or in ISSUE on the final step of the current command. On pop, the first step is registered onto the outputs on the same edge.
- **Step rules.**
  - SHIFT (010/011/100) with amt N>0: emit `op=cur_op`, `shamt=min(3,remain)`, then `remain -= shamt`. The final step is the one where `remain ≤ 3`.
  - Total steps for a shift = ceil(N/3). Example: N=7 gives shamt 3, 3, 1.
  - SHIFT with N=0: one step emitting `op=000`, `shamt=0`, with `done=1`.
  - LOAD: one step emitting `op=001`, `d_in=cmd_data`, `shamt=0`, `done=1`.
  - NOP or an illegal opcode: one step emitting `op=000`, with `done=1`.
  - `d_in` is 0 on every non-LOAD step.
- **Return to IDLE.** After a final step, if the FIFO is empty, the next edge loads the idle word (`op=000`, `shamt=0`, `d_in=0`, `done=0`) and the FSM returns to IDLE.
- **FIFO.**
  - Circular, with read/write pointers and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - A push and a pop on the same edge leave the count unchanged; this is legal at any fill level except full, where push is blocked.
  - Popping from empty never occurs; the pop enable is qualified by `!empty`.
- **Reset.**
  - On any edge with `reset=1`: FIFO emptied, FSM to IDLE, outputs set to the idle word.
  - `cmd_ready` is 1 after reset. `busy` is 0.
  - Reset mid-command discards the in-flight command and all buffered commands.
  - A command offered during a reset cycle is not accepted.

## Timing
- **Latency.** A command accepted at edge E0 into an empty FIFO while IDLE is popped at E1. Its first step is visible on the outputs after E1, and the shifter consumes it at E2.
- **Throughput.** One shifter operation per cycle, with no bubble between consecutive commands while the FIFO is non-empty.
- **`cmd_ready`.** Combinational from the registered count only; no path from `cmd_valid`.
- **`done`.** Aligned with the `op` of the command's last step.

## Structure
- **Package `shift_seq8_pkg`:**
  - opcode localparams OP_NOP, OP_LOAD, OP_LSL, OP_LSR, OP_ASR;
  - FSM state enum {S_IDLE, S_ISSUE};
  - packed command struct {op[2:0], amt[3:0], data[7:0]} (15 bits).
- **Sub-module:** one natural sub-module, `cmd_fifo`: a parameterised synchronous FIFO of the command struct exposing push, pop, full, empty and head.
- **Top level:** holds the FSM, the step counter and the output registers.

## Test plan
- Reset, then idle for 5 cycles → `op=000`, `shamt=0`, `d_in=0`, `done=0`, `busy=0`, `cmd_ready=1`.
- Push LOAD 8'hA5, then LSL amt 7 → consecutive cycles show (001, 0, A5, done=1), (010, 3), (010, 3), (010, 1, done=1), then idle. The shifter model reads A5 and then 8'h80 (A5 shifted left 7 within 8 bits).
- Push 6 commands back-to-back with no pops possible (e.g. five LSR amt 15 behind a LOAD) → `cmd_ready` falls after the FIFO is full. A held `cmd_valid` is accepted exactly when an entry frees up; no loss and no duplication, order preserved.
- ASR amt 0, then opcode 3'b110 → two single NOP steps, each with `done=1`. The shifter value is unchanged.
- Assert `reset` during step 2 of an LSR amt 9 with 2 commands queued → on the next edge the outputs are idle and `busy=0`. Nothing from the discarded commands is issued afterwards.
- Continuous pushes of LSL amt 3 → one step per command, `done` high every cycle, and the count stays stable under simultaneous push and pop.
